// File: rtl/vga_timing_if.sv
// Raster timing bundle from the VGA timing generator to its consumers.
interface vga_timing_if;
  logic       screenEnd;
  logic       active;
  logic       hSync;
  logic       vSync;
  logic [9:0] x;
  logic [8:0] y;

  modport master (output screenEnd, active, hSync, vSync, x, y);
  modport slave  (input  screenEnd, active, hSync, vSync, x, y);
endinterface

// File: rtl/vga_timing_generator.sv
// 640x480@60 raster timing: two free-running counters with combinational decodes.
// Define VGA_SYNC_DELAY_EN to delay hSync/vSync/active by two clocks to line up with image+palette RAM reads.
module vga_timing_generator #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic         clk25,
  input  logic         reset,
  vga_timing_if.master vga
);
  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(WIDTH);
  localparam logic [9:0] V_VIS    = 10'(HEIGHT);
  localparam logic [9:0] HS_START = 10'(WIDTH + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(HEIGHT + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(HEIGHT + V_FRONT + V_SYNC);
  localparam logic [8:0] Y_LAST   = 9'(HEIGHT - 1);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_t;

  logic [9:0] h_count, v_count;
  sync_t      sync_now;

  always_ff @(posedge clk25) begin
    if (!reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_MAX) begin
      h_count <= '0;
      v_count <= (v_count == V_MAX) ? 10'd0 : v_count + 10'd1;
    end else begin
      h_count <= h_count + 10'd1;
    end
  end

  always_comb begin
    sync_now.active = (h_count < H_VIS) && (v_count < V_VIS);
    sync_now.hsync  = !((h_count >= HS_START) && (h_count < HS_END));
    sync_now.vsync  = !((v_count >= VS_START) && (v_count < VS_END));
  end

  assign vga.screenEnd = (h_count == H_MAX) && (v_count == V_MAX);
  assign vga.x         = h_count;
  // y saturates on the last visible row so RAM addresses stay in range during vertical blanking
  assign vga.y         = (v_count < V_VIS) ? v_count[8:0] : Y_LAST;

`ifdef VGA_SYNC_DELAY_EN
  localparam int STAGES = 2;
  localparam sync_t SYNC_RST = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

  sync_t sync_pipe [STAGES:1];

  always_ff @(posedge clk25) begin
    if (!reset) begin
      for (int i = 1; i <= STAGES; i++) sync_pipe[i] <= SYNC_RST;
    end else begin
      sync_pipe[1] <= sync_now;
      for (int i = 2; i <= STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign vga.hSync  = sync_pipe[STAGES].hsync;
  assign vga.vSync  = sync_pipe[STAGES].vsync;
  assign vga.active = sync_pipe[STAGES].active;
`else
  assign vga.hSync  = sync_now.hsync;
  assign vga.vSync  = sync_now.vsync;
  assign vga.active = sync_now.active;
`endif
endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench: full-size 640x480 instance plus a shrunken-timing instance for whole-frame runs,
// both checked every cycle against a position-from-cycle-count model.
module tb_vga_timing_generator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  vga_timing_if vif_a ();
  vga_timing_if vif_b ();

  vga_timing_generator dut_a (.clk25(clk), .reset(rst_n), .vga(vif_a));

  vga_timing_generator #(
    .WIDTH(64), .HEIGHT(48), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_b (.clk25(clk), .reset(rst_n), .vga(vif_b));

  typedef struct packed {
    logic       se;
    logic       act;
    logic       hs;
    logic       vs;
    logic [9:0] x;
    logic [8:0] y;
  } exp_t;

  // Position is purely a function of clocks elapsed since reset.
  function automatic exp_t decode(int cyc, int w, int hf, int hs, int hb,
                                  int hh, int vf, int vs, int vb);
    int ht = w + hf + hs + hb;
    int vt = hh + vf + vs + vb;
    int h  = cyc % ht;
    int v  = (cyc / ht) % vt;
    exp_t e;
    e.se  = (cyc % (ht * vt)) == ht * vt - 1;
    e.act = (h < w) && (v < hh);
    e.hs  = !(h >= w + hf && h < w + hf + hs);
    e.vs  = !(v >= hh + vf && v < hh + vf + vs);
    e.x   = 10'(h);
    e.y   = (v < hh) ? 9'(v) : 9'(hh - 1);
    return e;
  endfunction

  int cyc_a = 0, cyc_b = 0;
  logic started = 1'b0;
  exp_t ea, eb;
  logic [2:0] pa1, pa2, pb1, pb2;   // {hs, vs, act} two-deep history for the delayed build

  always_comb ea = decode(cyc_a, 640, 16, 96, 48, 480, 10, 2, 33);
  always_comb eb = decode(cyc_b, 64, 4, 8, 4, 48, 2, 2, 3);

  always @(posedge clk) begin
    if (!rst_n) begin
      started <= 1'b1;
      cyc_a <= 0;
      cyc_b <= 0;
      pa1 <= 3'b110; pa2 <= 3'b110;
      pb1 <= 3'b110; pb2 <= 3'b110;
    end else begin
      cyc_a <= cyc_a + 1;
      cyc_b <= cyc_b + 1;
      pa1 <= {ea.hs, ea.vs, ea.act}; pa2 <= pa1;
      pb1 <= {eb.hs, eb.vs, eb.act}; pb2 <= pb1;
    end
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(string tag, exp_t e, logic [2:0] p, logic se, logic act,
                     logic hs, logic vs, logic [9:0] x, logic [8:0] y);
    logic [2:0] sv;
`ifdef VGA_SYNC_DELAY_EN
    sv = p;
`else
    sv = {e.hs, e.vs, e.act};
`endif
    check({tag, ".screenEnd"}, int'(se), int'(e.se));
    check({tag, ".x"}, int'(x), int'(e.x));
    check({tag, ".y"}, int'(y), int'(e.y));
    check({tag, ".hSync"}, int'(hs), int'(sv[2]));
    check({tag, ".vSync"}, int'(vs), int'(sv[1]));
    check({tag, ".active"}, int'(act), int'(sv[0]));
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp("a", ea, pa2, vif_a.screenEnd, vif_a.active, vif_a.hSync, vif_a.vSync, vif_a.x, vif_a.y);
      cmp("b", eb, pb2, vif_b.screenEnd, vif_b.active, vif_b.hSync, vif_b.vSync, vif_b.x, vif_b.y);
    end
  end

  initial begin
    int hs_low, act_hi, vs_low, se_cnt, se_idx;
    hs_low = 0; act_hi = 0; vs_low = 0; se_cnt = 0; se_idx = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rst.x", int'(vif_a.x), 0);
    check("rst.y", int'(vif_a.y), 0);
    check("rst.screenEnd", int'(vif_a.screenEnd), 0);
`ifdef VGA_SYNC_DELAY_EN
    check("rst.active", int'(vif_a.active), 0);
`else
    check("rst.active", int'(vif_a.active), 1);
`endif
    check("rst.hSync", int'(vif_a.hSync), 1);
    check("rst.vSync", int'(vif_a.vSync), 1);

    for (int i = 0; i < 4400; i++) begin
      if (i < 800) begin
        if (!vif_a.hSync) hs_low++;
        if (vif_a.active) act_hi++;
`ifdef VGA_SYNC_DELAY_EN
        if (i == 657) check("dly.hs_658_high", int'(vif_a.hSync), 1);
        if (i == 658) check("dly.hs_658_low", int'(vif_a.hSync), 0);
`else
        if (i == 656) check("hs_656_low", int'(vif_a.hSync), 0);
        if (i == 655) check("hs_655_high", int'(vif_a.hSync), 1);
`endif
      end
      if (!vif_b.vSync) vs_low++;
      if (vif_b.screenEnd) begin se_cnt++; se_idx = i; end
      @(negedge clk); #2;
      if (i == 799) begin
        check("line.x_wrap", int'(vif_a.x), 0);
        check("line.y_next", int'(vif_a.y), 1);
      end
    end
    check("line.hsync_low_clocks", hs_low, 96);
    check("line.active_clocks", act_hi, 640);
    check("frame.vsync_low_clocks", vs_low, 160);
    check("frame.screenEnd_count", se_cnt, 1);
    check("frame.screenEnd_index", se_idx, 4399);
    check("frame.x_home", int'(vif_b.x), 0);
    check("frame.y_home", int'(vif_b.y), 0);

    repeat (1630) @(negedge clk);
    check("mid.x_before", int'(vif_b.x), 30);
    check("mid.y_before", int'(vif_b.y), 20);
    rst_n = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    check("mid.x_after", int'(vif_b.x), 0);
    check("mid.y_after", int'(vif_b.y), 0);
    check("mid.screenEnd", int'(vif_b.screenEnd), 0);

    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(1, 2500)) @(negedge clk);
      rst_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (4500) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
